// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA transfer scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Descriptor field widths here set the scheduler's datapath. The top-level ADDR_WIDTH
// and LEN_WIDTH parameters must equal DESC_ADDR_W and DESC_LEN_W.
package dma_sched_pkg;

    localparam int DESC_ADDR_W = 16;
    localparam int DESC_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } sched_state_e;

    // Captured descriptor. len counts the beats still outstanding.
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src;
        logic [DESC_ADDR_W-1:0] dst;
        logic [DESC_LEN_W-1:0]  len;
    } xfer_desc_t;

    // Channel index width. This is kept at least 1 bit wide so that a
    // single-channel build still has a legal vector.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/dma_xfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping modulo NUM_CH.
// Latency: purely combinational, 0 cycles.
// Backpressure: none. The caller decides whether the grant is consumed.
// Ports: req (request vector), last_grant (previous winner), grant (one-hot), grant_idx (encoded).
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Scan offsets 1..NUM_CH from the last winner. The last winner itself
        // comes last, so it can win again only if it is the sole requester.
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dma_xfer_scheduler.sv
// Multi-channel DMA scheduler: accepts a descriptor from one of NUM_CH channels and steps a shared address generator beat by beat.
// Latency: handshake->first ag_start 1 cycle, ag_done->next ag_start 1 cycle, last ag_done->done_o 1 cycle.
// Backpressure: req_ready_o is high only in IDLE, for the round-robin winner. Other requests wait and are never dropped.
// Ports: req_valid_i/req_ready_o plus packed req_src_i/req_dst_i/req_len_i (channel c at [c*W +: W]);
//        ag_start_o/ag_src_o/ag_dst_o/ag_done_i to the address generator; busy_o, done_o, done_ch_o, err_o status.
// Optional macro DMA_SCHED_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES that aborts the transfer with an err_o pulse.
module dma_xfer_scheduler
    import dma_sched_pkg::*;
#(
    parameter  int ADDR_WIDTH     = DESC_ADDR_W,
    parameter  int NUM_CH         = 4,
    parameter  int LEN_WIDTH      = DESC_LEN_W,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int CH_IDX_W       = ch_idx_w(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic [NUM_CH-1:0]            req_valid_i,
    output logic [NUM_CH-1:0]            req_ready_o,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_src_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_dst_i,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  req_len_i,
    output logic                         ag_start_o,
    output logic [ADDR_WIDTH-1:0]        ag_src_o,
    output logic [ADDR_WIDTH-1:0]        ag_dst_o,
    input  logic                         ag_done_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CH_IDX_W-1:0]          done_ch_o,
    output logic                         err_o
);

    sched_state_e        state_q, state_d;
    xfer_desc_t          desc_q, desc_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [CH_IDX_W-1:0] last_grant_q, last_grant_d;
    logic [NUM_CH-1:0]   grant;
    logic [CH_IDX_W-1:0] grant_idx;
    logic                start_d;
    logic                tmo_hit;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_IDX_W)
    ) u_arb (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // This output is combinational from valid and state. The rest of the
    // interface is registered.
    assign req_ready_o = (state_q == ST_IDLE) ? grant : '0;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // The counter counts WAIT cycles and restarts on every other state, so
    // each ISSUE starts a fresh window. A done on the final cycle still wins.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && !ag_done_i &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        desc_d       = desc_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    desc_d.src   = req_src_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    desc_d.dst   = req_dst_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    desc_d.len   = req_len_i[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
                    ch_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A zero-length descriptor passes through ISSUE without
                // raising a start pulse.
                state_d = (desc_q.len == '0) ? ST_COMPLETE : ST_WAIT;
            end
            ST_WAIT: begin
                if (ag_done_i) begin
                    desc_d.src = desc_q.src + 1'b1;
                    desc_d.dst = desc_q.dst + 1'b1;
                    desc_d.len = desc_q.len - 1'b1;
                    state_d    = (desc_q.len == DESC_LEN_W'(1)) ? ST_COMPLETE : ST_ISSUE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are loaded from the next-state values, so they line
    // up with the state they describe.
    assign start_d = (state_d == ST_ISSUE) && (desc_d.len != '0);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            desc_q       <= '0;
            ch_q         <= '0;
            last_grant_q <= CH_IDX_W'(NUM_CH - 1);
            ag_start_o   <= 1'b0;
            ag_src_o     <= '0;
            ag_dst_o     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            done_ch_o    <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            desc_q       <= desc_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
            ag_start_o   <= start_d;
            if (start_d) begin
                ag_src_o <= desc_d.src;
                ag_dst_o <= desc_d.dst;
            end
            busy_o <= (state_d != ST_IDLE);
            done_o <= (state_d == ST_COMPLETE);
            err_o  <= tmo_hit;
            if ((state_d == ST_COMPLETE) || tmo_hit) begin
                done_ch_o <= ch_d;
            end
        end
    end

endmodule

// File: doc/dma_xfer_scheduler.md
# dma_xfer_scheduler

Multi-channel transfer scheduler that shares one `address_generator` among `NUM_CH` requesting channels. It accepts a transfer descriptor (source base, destination base, beat count) from each channel, picks one by round-robin, and sequences the address generator beat by beat. It steps the addresses and signals per-channel completion. It sits between the channel request logic and the `address_generator` instance in the DMA datapath.

## Interface
- `ADDR_WIDTH`, 16, address width; must match the `address_generator` instance
- `NUM_CH`, 4, number of requesting channels (2..8)
- `LEN_WIDTH`, 8, width of the beat-count field
- `TIMEOUT_CYCLES`, 64, watchdog limit per beat; used only with `DMA_SCHED_TIMEOUT_EN`
- `clk_i`  in  1  clock; all logic is rising-edge
- `resetn_i`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  NUM_CH  per-channel descriptor valid
- `req_ready_o`  out  NUM_CH  per-channel accept; one-hot or zero
- `req_src_i`  in  NUM_CH×ADDR_WIDTH  packed source bases; channel c is at `[c*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_dst_i`  in  NUM_CH×ADDR_WIDTH  packed destination bases
- `req_len_i`  in  NUM_CH×LEN_WIDTH  packed beat counts
- `ag_start_o`  out  1  single-cycle start pulse to the address generator
- `ag_src_o` / `ag_dst_o`  out  ADDR_WIDTH  beat addresses, valid while `ag_start_o` is high
- `ag_done_i`  in  1  beat completion from the address generator
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  single-cycle transfer-complete pulse
- `done_ch_o`  out  $clog2(NUM_CH)  channel index qualified by `done_o` or `err_o`
- `err_o`  out  1  single-cycle timeout-abort pulse

## Operation
- States are IDLE, ISSUE, WAIT and COMPLETE.
- **IDLE**
  - If any `req_valid_i` is high, the round-robin grant drives `req_ready_o` combinationally, one-hot for the winner.
  - On that edge the block captures src, dst, len and the channel index, then moves to ISSUE.
  - If the captured len is 0, the block goes straight to COMPLETE and issues no `ag_start_o`.
- **ISSUE**
  - `ag_start_o`=1 for exactly one cycle, with the current src/dst on `ag_src_o`/`ag_dst_o`. Next state is WAIT.
  - `ag_done_i` is ignored in ISSUE.
- **WAIT**
  - The block holds until `ag_done_i`=1 is sampled.
  - On that edge: src+=1, dst+=1 (modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000), remaining-=1.
  - If remaining was 1, go to COMPLETE; otherwise go to ISSUE.
- **COMPLETE**
  - `done_o`=1 and `done_ch_o`=the captured channel, for one cycle. Then go to IDLE.
- **Round-robin arbitration**
  - Priority starts at (last_grant+1) mod NUM_CH.
  - last_grant updates only on an accepted handshake.
  - After reset, last_grant=NUM_CH-1, so channel 0 has top priority.
- A descriptor changing while it is not yet accepted has no effect. Values are sampled only on the handshake edge.
- `req_ready_o` is 0 in every state except IDLE. New requests wait; no request is dropped.
- Asserting reset mid-transfer aborts the transfer with no `done_o`. All state returns to reset values.

## Timing
- Reset values: `req_ready_o`=0, `ag_start_o`=0, `ag_src_o`=0, `ag_dst_o`=0, `busy_o`=0, `done_o`=0, `done_ch_o`=0, `err_o`=0. Internal state is IDLE.
- Handshake to first `ag_start_o`: 1 cycle.
- `ag_done_i` to next `ag_start_o`: 1 cycle.
- Minimum of 2 cycles per beat when `ag_done_i` returns in the first WAIT cycle.
- Last `ag_done_i` to `done_o`: 1 cycle. `done_o` to the next possible handshake: 1 cycle.
- All outputs are registered except `req_ready_o`, which is combinational from `req_valid_i` and the state.

## Configuration
- `DMA_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on each ISSUE.
  - If it reaches `TIMEOUT_CYCLES` without `ag_done_i`, the block pulses `err_o` for one cycle with `done_ch_o`=the channel, drops the transfer (no `done_o`), and returns to IDLE.
- Not defined: WAIT holds indefinitely, `err_o` is tied to 0, and no counter is built.

## Structure
- Package `dma_sched_pkg` holds:
  - the state enum `sched_state_e`
  - `CH_IDX_W` as `$clog2(NUM_CH)` in function form
  - the descriptor struct `xfer_desc_t` {src, dst, len}
- One sub-module, `rr_arbiter`: NUM_CH request vector and last_grant in, one-hot grant and encoded index out. It is purely combinational.

## Test plan
- **Single transfer:** ch0 src=0x1111, dst=0x2222, len=3, `ag_done_i` returned 1 cycle after each start -> three starts with (0x1111,0x2222), (0x1112,0x2223), (0x1113,0x2224); then `done_o` with `done_ch_o`=0.
- **Round-robin:** all 4 channels valid with len=1 and kept valid -> grant order 0,1,2,3,0 across successive transfers.
- **Wrap-around:** src=0xFFFF, dst=0xFFFE, len=3 -> src sequence FFFF,0000,0001; dst sequence FFFE,FFFF,0000.
- **Zero length:** ch2 len=0 -> no `ag_start_o`; `done_o` with `done_ch_o`=2 two cycles after the handshake.
- **Reset mid-transfer:** assert `resetn_i`=0 during WAIT of beat 2 of a len=5 transfer -> all outputs 0 immediately, no `done_o`; after release, ch0 wins first.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** `ag_done_i` held at 0 -> `err_o` pulse 8 cycles into WAIT, then IDLE, with `busy_o`=0.
